sopc3_angle_mesure: RTL

//  Avalon-MM slave input port returning measured rudder angle from the external sensor interface to the Nios II.

---
 rtl/sopc3_angle_mesure_pkg.sv | 26 ++
 rtl/sopc3_angle_mesure_if.sv | 26 ++
 rtl/sopc3_angle_mesure_sync_edge.sv | 49 ++++
 rtl/sopc3_angle_mesure.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sopc3_angle_mesure_pkg.sv
// Shared definitions for the rudder-angle input port.
// Holds the register word offsets, the STATUS bit positions and a small
// helper that zero-extends a register field onto the 32-bit read bus.
package sopc3_angle_mesure_pkg;

    // Register word offsets on the Avalon-MM slave.
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    // STATUS / MASK bit positions.
    localparam int ST_NEW = 0;
    localparam int ST_OVR = 1;

    // Sticky sample flags, packed in register bit order.
    typedef struct packed {
        logic ovr;
        logic fresh;
    } status_t;

    function automatic logic [31:0] status_word(input status_t s);
        return {30'd0, s};
    endfunction

endpackage

// File: rtl/sopc3_angle_mesure_if.sv
// Avalon-MM slave bus bundle for the angle input port.
//   address    word address (DATA/MASK/STATUS/COUNT)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero wait states
// Bus protocol: a write happens on the clock edge that sees
// chipselect=1 and write_n=0; there is no wait/ready signalling, every
// access completes in one cycle and reads have no side effects.
interface sopc3_angle_mesure_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/sopc3_angle_mesure_sync_edge.sv
// SYNC_N-stage synchroniser with rising-edge pulse.
//   clk, reset_n  clock and asynchronous active-low reset
//   d_in   [W]    asynchronous input
//   d_sync [W]    synchronised level (last synchroniser stage)
//   rise   [W]    one-cycle pulse per 0->1 transition of d_sync
// The edge flop resets to 0, so an input already high when reset is
// released produces exactly one rise pulse.
module sopc3_angle_mesure_sync_edge #(
    parameter int W      = 1,
    parameter int SYNC_N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_sync,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync_q [SYNC_N];
    logic [W-1:0] sync_d [SYNC_N];
    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < SYNC_N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_q[SYNC_N-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= sync_d[i];
            end
            dly_q <= dly_d;
        end
    end

    assign d_sync = sync_q[SYNC_N-1];
    assign rise   = d_sync & ~dly_q;

endmodule

// File: rtl/sopc3_angle_mesure.sv
// Avalon-MM slave returning the measured rudder angle to the CPU.
//   clk, reset_n   system clock, asynchronous active-low reset
//   bus            Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port [DATA_W] sensor angle, asynchronous, stable while in_valid=1
//   in_valid       sensor strobe, asynchronous
//   irq            level interrupt, |(STATUS & MASK)
// Registers: 0 DATA (RO), 1 MASK (RW, 2 bits), 2 STATUS (W1C: NEW, OVR),
// 3 COUNT (wrapping capture counter, any write clears).
module sopc3_angle_mesure
    import sopc3_angle_mesure_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sopc3_angle_mesure_if.slave   bus,
    input  logic [DATA_W-1:0]     in_port,
    input  logic                  in_valid,
    output logic                  irq
);

    logic              valid_sync_unused;
    logic              cap;
    logic [DATA_W-1:0] port_sync;
    logic [DATA_W-1:0] port_rise_unused;
    logic [29:0]       wdata_unused;

    logic [DATA_W-1:0] data_q,   data_d;
    logic [1:0]        mask_q,   mask_d;
    status_t           status_q, status_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic wr;
    logic wr_mask;
    logic wr_status;
    logic wr_count;

    sopc3_angle_mesure_sync_edge #(.W(1), .SYNC_N(SYNC_N)) u_valid_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (in_valid),
        .d_sync  (valid_sync_unused),
        .rise    (cap)
    );

    // in_port only needs its level; it is stable while in_valid is high,
    // so it has settled through the same depth by the time cap fires.
    sopc3_angle_mesure_sync_edge #(.W(DATA_W), .SYNC_N(SYNC_N)) u_port_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (in_port),
        .d_sync  (port_sync),
        .rise    (port_rise_unused)
    );

    assign wdata_unused = bus.writedata[31:2];

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_mask   = wr && (bus.address == ADDR_MASK);
    assign wr_status = wr && (bus.address == ADDR_STATUS);
    assign wr_count  = wr && (bus.address == ADDR_COUNT);

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        status_d = status_q;
        count_d  = count_q;

        if (wr_mask) begin
            mask_d = bus.writedata[1:0];
        end

        if (wr_status) begin
            if (bus.writedata[ST_NEW]) status_d.fresh = 1'b0;
            if (bus.writedata[ST_OVR]) status_d.ovr   = 1'b0;
        end

        if (wr_count) begin
            count_d = '0;
        end

        // A capture overrides a same-cycle clear; overrun is judged on the
        // NEW flag as it stood before any clear in this cycle.
        if (cap) begin
            data_d         = port_sync;
            status_d.fresh = 1'b1;
            if (status_q.fresh) status_d.ovr = 1'b1;
            count_d        = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            mask_q   <= '0;
            status_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = {{(32-DATA_W){1'b0}}, data_q};
            ADDR_MASK:   bus.readdata = {30'd0, mask_q};
            ADDR_STATUS: bus.readdata = status_word(status_q);
            ADDR_COUNT:  bus.readdata = {{(32-CNT_W){1'b0}}, count_q};
            default:     bus.readdata = '0;
        endcase
    end

    assign irq = |(status_q & mask_q);

endmodule
